// File: rtl/dds_wave_gen_pkg.sv
// Shared definitions for the DDS waveform generator: default widths and the
// waveform select encoding used by the control logic and the output mux.
package dds_pkg;

   localparam int DDS_ACC_W   = 32;
   localparam int DDS_PHASE_W = 12;
   localparam int DDS_OUT_W   = 24;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_SQR  = 3'd1,
      SEL_SAW  = 3'd2,
      SEL_TRI  = 3'd3,
      SEL_SIN  = 3'd4
   } dds_sel_e;

endpackage

// File: rtl/dds_wave_gen_if.sv
// Control/sample bus between the register logic (master) and the DDS
// generator (slave). Carries tuning, shaping controls and the output sample.
interface dds_wave_gen_if
   import dds_pkg::*;
#(
   parameter int ACC_W   = DDS_ACC_W,
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int OUT_W   = DDS_OUT_W
);

   logic               en;
   logic [ACC_W-1:0]   ftw_in;
   logic               ftw_load;
   logic [PHASE_W-1:0] phase_off;
   logic [PHASE_W-1:0] duty;
   logic [2:0]         sel;
   logic [OUT_W-1:0]   wave_out;
   logic               out_valid;

   modport master (
      output en, ftw_in, ftw_load, phase_off, duty, sel,
      input  wave_out, out_valid
   );

   modport slave (
      input  en, ftw_in, ftw_load, phase_off, duty, sel,
      output wave_out, out_valid
   );

endinterface

// File: rtl/dds_wave_gen_sine_rom.sv
// Quarter-wave sine magnitude ROM. Entry i holds
// round((2^(OUT_W-1)-1) * sin(pi*i/(2Q))) with Q = 2^(PHASE_W-2); the table
// is built from a constant function, and the read is registered.
module sine_quarter_rom
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int OUT_W   = DDS_OUT_W
)(
   input  logic               clk,
   input  logic [PHASE_W-3:0] raddr,
   output logic [OUT_W-2:0]   dout
);

   localparam int DEPTH = 1 << (PHASE_W - 2);

   function automatic logic [OUT_W-2:0] sineMag(input int idx);
      real fullScale;
      real angle;
      fullScale = real'((64'd1 << (OUT_W - 1)) - 64'd1);
      angle     = 3.14159265358979323846 * real'(idx) / (2.0 * real'(DEPTH));
      return (OUT_W-1)'($rtoi(fullScale * $sin(angle) + 0.5));
   endfunction

   logic [OUT_W-2:0] w_table [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : genTable
      assign w_table[g] = sineMag(g);
   end

   // Registered lookup so the ROM maps onto a synchronous block memory
   always_ff @(posedge clk) begin
      dout <= w_table[raddr];
   end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator with phase-continuous tuning
// word updates, followed by a 3-stage pipeline (phase index, waveform
// shaping / sine lookup, output select) producing an offset-binary sample.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int ACC_W   = DDS_ACC_W,
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int OUT_W   = DDS_OUT_W
)(
   input  logic         clk,
   input  logic         rst,
   dds_wave_gen_if.slave bus
);

   localparam int S  = OUT_W - PHASE_W;
   localparam int QW = PHASE_W - 2;

   // Accumulator and tuning word state
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_ftwAct;
   logic [ACC_W-1:0]   r_ftwPend;
   logic               r_pendFlag;

   logic [ACC_W:0]     w_sum;
   logic               w_carry;
   logic               w_idle;
   logic               w_apply;

   // Stage 1: phase index and sideband
   logic [PHASE_W-1:0] r_s1P;
   logic [2:0]         r_s1Sel;
   logic               r_s1Valid;

   logic [1:0]         w_quad;
   logic [QW-1:0]      w_off;
   logic [QW-1:0]      w_romAddr;
   logic [PHASE_W-2:0] w_tri;
   logic [OUT_W-2:0]   w_romMag;

   // Stage 2: shaped waveforms
   logic               r_s2Sqr;
   logic [OUT_W-1:0]   r_s2Saw;
   logic [OUT_W-1:0]   r_s2Tri;
   logic               r_s2Neg;
   logic               r_s2Full;
   logic [2:0]         r_s2Sel;
   logic               r_s2Valid;

   logic [OUT_W-2:0]   w_sineMag;
   logic [OUT_W-1:0]   w_sine;
   logic [OUT_W-1:0]   w_mux;

   // Stage 3: output sample
   logic [OUT_W-1:0]   r_waveOut;
   logic               r_outValid;

   assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftwAct};
   assign w_carry = w_sum[ACC_W];
   assign w_idle  = (r_ftwAct == '0);
   // A zero step can never wrap, so an idle generator picks up the pending
   // word immediately; otherwise the swap waits for a wrap to stay phase-continuous.
   assign w_apply = r_pendFlag && (w_idle || (bus.en && w_carry));

   // Phase accumulator and pending/active tuning word handover
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= '0;
         r_ftwAct   <= '0;
         r_ftwPend  <= '0;
         r_pendFlag <= 1'b0;
      end else begin
         if (bus.en) begin
            r_acc <= w_sum[ACC_W-1:0];
         end
         if (w_apply) begin
            r_ftwAct   <= r_ftwPend;
            r_pendFlag <= 1'b0;
         end
         if (bus.ftw_load) begin
            r_ftwPend  <= bus.ftw_in;
            r_pendFlag <= 1'b1;
         end
      end
   end

   // Stage 1: offset phase index plus the controls that travel with it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1P     <= '0;
         r_s1Sel   <= '0;
         r_s1Valid <= 1'b0;
      end else begin
         r_s1P     <= r_acc[ACC_W-1 -: PHASE_W] + bus.phase_off;
         r_s1Sel   <= bus.sel;
         r_s1Valid <= bus.en;
      end
   end

   assign w_quad    = r_s1P[PHASE_W-1 -: 2];
   assign w_off     = r_s1P[QW-1:0];
   assign w_romAddr = w_quad[0] ? (-w_off) : w_off;
   assign w_tri     = r_s1P[PHASE_W-1] ? ~r_s1P[PHASE_W-2:0] : r_s1P[PHASE_W-2:0];

   sine_quarter_rom #(
      .PHASE_W (PHASE_W),
      .OUT_W   (OUT_W)
   ) u_sineRom (
      .clk   (clk),
      .raddr (w_romAddr),
      .dout  (w_romMag)
   );

   // Stage 2: square/saw/triangle shaping alongside the sine ROM read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2Sqr   <= 1'b0;
         r_s2Saw   <= '0;
         r_s2Tri   <= '0;
         r_s2Neg   <= 1'b0;
         r_s2Full  <= 1'b0;
         r_s2Sel   <= '0;
         r_s2Valid <= 1'b0;
      end else begin
         r_s2Sqr   <= (r_s1P < bus.duty);
         r_s2Saw   <= {r_s1P, {S{1'b0}}};
         r_s2Tri   <= {w_tri, {(S + 1){1'b0}}};
         r_s2Neg   <= w_quad[1];
         r_s2Full  <= w_quad[0] && (w_off == '0);
         r_s2Sel   <= r_s1Sel;
         r_s2Valid <= r_s1Valid;
      end
   end

   // Sine reconstruction around mid-scale and waveform select
   always_comb begin
      w_sineMag = r_s2Full ? {(OUT_W - 1){1'b1}} : w_romMag;
      w_sine    = r_s2Neg ? ({1'b1, {(OUT_W - 1){1'b0}}} - {1'b0, w_sineMag})
                          : ({1'b1, {(OUT_W - 1){1'b0}}} + {1'b0, w_sineMag});
      w_mux     = '0;
      case (r_s2Sel)
         SEL_SQR: w_mux = {OUT_W{r_s2Sqr}};
         SEL_SAW: w_mux = r_s2Saw;
         SEL_TRI: w_mux = r_s2Tri;
         SEL_SIN: w_mux = w_sine;
         default: w_mux = '0;
      endcase
   end

   // Stage 3: registered output sample and its valid flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_waveOut  <= '0;
         r_outValid <= 1'b0;
      end else begin
         r_waveOut  <= w_mux;
         r_outValid <= r_s2Valid;
      end
   end

   assign bus.wave_out  = r_waveOut;
   assign bus.out_valid = r_outValid;

endmodule
